icache_responder: RTL and testbench

Instruction-side memory responder for the LC-3b pipeline. It answers the fetch stage's per-cycle instruction lookup with `instr` and the ready flag `imem_r`. It holds a small direct-mapped, one-word-per-line instruction cache. On a miss it fetches the word from backing memory over a req/ack handshake, and `imem_r` stays low until the line is filled. It sits between the fetch stage (PC in; `instr`/`imem_r` out) and the unified memory model.

---
 rtl/lc3b_icache_pkg.sv | 20 ++
 rtl/icache_line_array.sv | 49 ++++
 rtl/icache_responder.sv | 105 ++++++++++
 tb/tb_icache_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_icache_pkg.sv
// Shared types and width helpers for the LC-3b instruction-side cache responder.
package lc3b_icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } icache_state_t;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Bit 0 is the byte offset inside a word, so the tag starts above the index.
  function automatic int tag_w(input int lines, input int addr_w);
    return addr_w - 1 - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for a direct-mapped, one-word-per-line instruction cache.
module icache_line_array
  import lc3b_icache_pkg::*;
#(
  parameter int  LINES  = 8,
  parameter int  ADDR_W = 16,
  localparam int IDX_W  = idx_w(LINES),
  localparam int TAG_W  = tag_w(LINES, ADDR_W)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [ADDR_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic              wr_valid
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [ADDR_W-1:0] data_q [LINES];

  // Clear beats a same-cycle write, so a fill racing a flush lands invalid.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= wr_valid;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; the valid bits alone
  // decide whether their contents mean anything, which keeps them RAM-mappable.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_responder.sv
// Fetch-side responder: combinational hit lookup, single outstanding miss refill.
module icache_responder
  import lc3b_icache_pkg::*;
#(
  parameter int  LINES  = 8,
  parameter int  ADDR_W = 16,
  localparam int IDX_W  = idx_w(LINES),
  localparam int TAG_W  = tag_w(LINES, ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              flush,
  output logic [ADDR_W-1:0] instr,
  output logic              imem_r,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  icache_state_t     state_q;
  logic [ADDR_W-1:0] miss_pc;
  logic              flush_pend;
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [ADDR_W-1:0] rd_data;
  logic              lookup_hit;
  logic              hit;
  logic              miss_start;
  logic              fill;
  logic              pc_lsb_unused;

  assign pc_lsb_unused = pc[0];

  assign lookup_hit = fetch_en && rd_valid && (rd_tag == pc[ADDR_W-1:IDX_W+1]);
  assign hit        = (state_q == IDLE) && lookup_hit && !flush;
  assign miss_start = (state_q == IDLE) && fetch_en && !lookup_hit && !flush;
  // Qualifying with rst_n drops a fill whose ack coincides with reset.
  assign fill       = (state_q == REQ) && mem_ack && rst_n;

  assign imem_r   = hit;
  assign instr    = hit ? rd_data : NOP_WORD;
  assign mem_req  = (state_q == REQ);
  assign mem_addr = miss_pc;

  icache_line_array #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W)
  ) u_lines (
    .clk      (clk),
    .clr      (flush || !rst_n),
    .rd_idx   (pc[IDX_W:1]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill),
    .wr_idx   (miss_pc[IDX_W:1]),
    .wr_tag   (miss_pc[ADDR_W-1:IDX_W+1]),
    .wr_data  (mem_rdata),
    .wr_valid (!(flush_pend || flush))
  );

  // NOTE: every register here uses <= so all of them see pre-edge values;
  // a blocking update would leak into later reads within the same block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      miss_pc    <= '0;
      flush_pend <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      if (hit && hit_cnt != 16'hFFFF) begin
        hit_cnt <= hit_cnt + 16'd1;
      end
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            miss_pc <= {pc[ADDR_W-1:1], 1'b0};
            state_q <= REQ;
            if (miss_cnt != 16'hFFFF) begin
              miss_cnt <= miss_cnt + 16'd1;
            end
          end
        end
        REQ: begin
          // A flush never aborts the refill; it only poisons the returned line.
          if (mem_ack) begin
            state_q    <= IDLE;
            flush_pend <= 1'b0;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed timing checks plus a randomized scoreboard run against a line-level cache model.
module tb_icache_responder;

  localparam int LINES = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        fetch_en;
  logic        flush;
  logic [15:0] instr;
  logic        imem_r;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  icache_responder #(.LINES(LINES), .ADDR_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .fetch_en  (fetch_en),
    .flush     (flush),
    .instr     (instr),
    .imem_r    (imem_r),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial forever #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Backing memory: ack three cycles after mem_req rises, data = addr ^ A5A5.
  int          mcnt = 0;
  logic        req_prev = 1'b0;
  logic [15:0] cap_addr = '0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mcnt == 0 && mem_req === 1'b1 && !req_prev) begin
        mcnt     = 1;
        cap_addr = mem_addr;
      end else if (mcnt != 0) begin
        mcnt++;
      end
      if (mcnt == 3) begin
        mem_ack   = 1'b1;
        mem_rdata = cap_addr ^ 16'hA5A5;
        mcnt      = 0;
      end
      req_prev = (mem_req === 1'b1);
    end
  end

  // Scoreboard monitor: expected hits and refill addresses, in issue order.
  bit          sb_on = 1'b0;
  logic [15:0] hit_q[$];
  logic [15:0] miss_q[$];
  logic        mreq_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (sb_on) begin
      if (imem_r === 1'b1) begin
        check("sb_hit_expected", hit_q.size() != 0, 1);
        if (hit_q.size() != 0) check("sb_instr", instr, hit_q.pop_front());
      end else begin
        check("sb_instr_nop", instr, 16'h0000);
      end
      if (mem_req === 1'b1 && !mreq_prev) begin
        check("sb_miss_expected", miss_q.size() != 0, 1);
        if (miss_q.size() != 0) check("sb_mem_addr", mem_addr, miss_q.pop_front());
      end
      check("sb_ready_vs_ack", imem_r & mem_ack, 0);
    end
    mreq_prev = (mem_req === 1'b1);
  end

  // Present one fetch and wait for imem_r; lat counts cycles from presentation.
  task automatic run_fetch(input logic [15:0] a, input int exp_lat, input string nm);
    int          lat = -1;
    bit          saw_req = 1'b0;
    logic [15:0] got = '0;
    pc = a; fetch_en = 1'b1; flush = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && !saw_req) begin
        saw_req = 1'b1;
        check({nm, "_mem_addr"}, mem_addr, {a[15:1], 1'b0});
      end
      if (imem_r === 1'b1) begin
        lat = c;
        got = instr;
        break;
      end
    end
    check({nm, "_latency"}, lat, exp_lat);
    if (lat >= 0) check({nm, "_instr"}, got, {a[15:1], 1'b0} ^ 16'hA5A5);
    step();
    fetch_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 1'b0; flush = 1'b0; pc = '0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // Reference model: which word address each line holds.
  logic [15:0] m_addr[LINES];
  bit          m_v[LINES];
  int          m_hit, m_miss;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; flush = 1'b0; pc = '0;
    do_reset();

    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_imem_r", imem_r, 0);
    check("rst_instr", instr, 16'h0000);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_hit_cnt", dut.hit_cnt, 0);
    check("rst_miss_cnt", dut.miss_cnt, 0);
    step();

    // 1: cold miss with cycle-exact timing
    pc = 16'h3000; fetch_en = 1'b1;
    @(negedge clk); check("t1_c0_imem_r", imem_r, 0); check("t1_c0_mem_req", mem_req, 0);
    step(); @(negedge clk); check("t1_c1_mem_req", mem_req, 1); check("t1_c1_mem_addr", mem_addr, 16'h3000);
    step(); @(negedge clk); check("t1_c2_mem_req", mem_req, 1);
    step(); @(negedge clk); check("t1_c3_mem_req", mem_req, 1); check("t1_c3_imem_r", imem_r, 0);
    step(); @(negedge clk);
    check("t1_c4_imem_r", imem_r, 1);
    check("t1_c4_instr", instr, 16'h95A5);
    check("t1_c4_mem_req", mem_req, 0);
    check("t1_c4_miss_cnt", dut.miss_cnt, 1);
    step(); fetch_en = 1'b0;

    // 2: sequential hits
    run_fetch(16'h3002, 4, "t2_fill");
    run_fetch(16'h3000, 0, "t2_hit_3000");
    run_fetch(16'h3002, 0, "t2_hit_3002");
    check("t2_hit_cnt", dut.hit_cnt, 4);
    check("t2_miss_cnt", dut.miss_cnt, 2);

    // 3: conflict miss on index 0
    run_fetch(16'h3010, 4, "t3_conflict");
    run_fetch(16'h3000, 4, "t3_evicted");

    // 4: redirect during REQ
    pc = 16'h3004; fetch_en = 1'b1;
    @(negedge clk); check("t4_c0_imem_r", imem_r, 0);
    step(); @(negedge clk); check("t4_c1_mem_req", mem_req, 1);
    step(); pc = 16'h4ABC;
    @(negedge clk); check("t4_c2_mem_addr", mem_addr, 16'h3004); check("t4_c2_imem_r", imem_r, 0);
    step(); @(negedge clk); check("t4_c3_mem_addr", mem_addr, 16'h3004); check("t4_c3_imem_r", imem_r, 0);
    step(); @(negedge clk); check("t4_c4_imem_r", imem_r, 0); check("t4_c4_mem_req", mem_req, 0);
    step(); @(negedge clk); check("t4_c5_mem_req", mem_req, 1); check("t4_c5_mem_addr", mem_addr, 16'h4ABC);
    step(); step(); step(); @(negedge clk);
    check("t4_c8_imem_r", imem_r, 1); check("t4_c8_instr", instr, 16'hEF19);
    step(); fetch_en = 1'b0;
    run_fetch(16'h3004, 0, "t4_line2");

    // 5: flush mid-REQ
    pc = 16'h3006; fetch_en = 1'b1;
    step(); step(); flush = 1'b1;
    @(negedge clk); check("t5_c2_imem_r", imem_r, 0);
    step(); flush = 1'b0;
    @(negedge clk); check("t5_c3_mem_req", mem_req, 1);
    step(); fetch_en = 1'b0;
    @(negedge clk); check("t5_c4_mem_req", mem_req, 0); check("t5_c4_valid", dut.u_lines.valid_q, 0);
    step();
    run_fetch(16'h3006, 4, "t5_refetch");
    run_fetch(16'h3000, 4, "t5_old_line");

    // 6: reset mid-REQ, late ack ignored
    pc = 16'h3008; fetch_en = 1'b1;
    step(); @(negedge clk); check("t6_c1_mem_req", mem_req, 1);
    step(); rst_n = 1'b0; fetch_en = 1'b0;
    step(); rst_n = 1'b1;
    @(negedge clk); check("t6_c3_mem_req", mem_req, 0);
    step(); @(negedge clk);
    check("t6_valid", dut.u_lines.valid_q, 0);
    check("t6_hit_cnt", dut.hit_cnt, 0);
    check("t6_miss_cnt", dut.miss_cnt, 0);
    check("t6_mem_req", mem_req, 0);
    step();
    run_fetch(16'h3008, 4, "t6_refetch");

    // Randomized scoreboard phase
    do_reset();
    for (int i = 0; i < LINES; i++) m_v[i] = 1'b0;
    m_hit = 0; m_miss = 0;
    sb_on = 1'b1;
    for (int t = 0; t < 300; t++) begin
      logic [15:0] a, word;
      int          li;
      bit          got;
      if ($urandom_range(0, 15) == 0) begin
        flush = 1'b1; fetch_en = 1'b0;
        step();
        flush = 1'b0;
        for (int i = 0; i < LINES; i++) m_v[i] = 1'b0;
      end
      a = 16'h3000 + 16'(($urandom_range(0, 2) << 5) | ($urandom_range(0, 15) << 1)
                         | $urandom_range(0, 1));
      word = {a[15:1], 1'b0};
      li = int'(word >> 1) % LINES;
      if (!(m_v[li] && m_addr[li] == word)) begin
        miss_q.push_back(word);
        m_miss++;
        m_v[li] = 1'b1;
        m_addr[li] = word;
      end
      hit_q.push_back(word ^ 16'hA5A5);
      m_hit++;
      pc = a; fetch_en = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (imem_r === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      check("rand_ready_in_budget", got, 1);
      step();
      fetch_en = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    step(); step();
    sb_on = 1'b0;
    check("rand_hits_left", hit_q.size(), 0);
    check("rand_misses_left", miss_q.size(), 0);
    check("rand_hit_cnt", dut.hit_cnt, m_hit);
    check("rand_miss_cnt", dut.miss_cnt, m_miss);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
